// File: rtl/seletor_estado_botoes_pkg.sv
// ---------------------------------------------------------------------------
// pkg_tamagotchi
// Shared types and constants for the button-driven image selector.
//   sel_state_e        : selector FSM states (IDLE / PENDING)
//   BTN_NEXT/PREV/HOME : bit positions of the three navigation buttons
//   AUTO_REPEAT_DELAY  : hold time (cycles) before the first repeat pulse
//   AUTO_REPEAT_PERIOD : cycles between later repeat pulses
// The repeat constants are only used when SELETOR_AUTO_REPEAT_EN is
// defined. Defining SELETOR_REPEAT_SIM_SCALE shrinks them for simulation.
// ---------------------------------------------------------------------------
package pkg_tamagotchi;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sel_state_e;

  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_HOME = 2;

`ifdef SELETOR_REPEAT_SIM_SCALE
  localparam int AUTO_REPEAT_DELAY  = 40;
  localparam int AUTO_REPEAT_PERIOD = 10;
`else
  localparam int AUTO_REPEAT_DELAY  = 12500000;
  localparam int AUTO_REPEAT_PERIOD = 2500000;
`endif

endpackage

// File: rtl/seletor_estado_botoes_if.sv
// ---------------------------------------------------------------------------
// seletor_estado_botoes_if
// Bundles the selector's button, display-handshake and status signals.
//   b_in       : raw buttons (bit0 next, bit1 prev, bit2 home)
//   frame_done : one-cycle end-of-transfer pulse from the display controller
//   estado     : committed image index
//   b_event    : one-cycle press pulse per debounced button
//   pending    : a state change is waiting for frame_done
// master = environment side (drives buttons/frame_done), slave = selector.
// ---------------------------------------------------------------------------
interface seletor_estado_botoes_if #(
  parameter int N_BUTTONS = 3,
  parameter int STATE_W   = 2
);

  logic [N_BUTTONS-1:0] b_in;
  logic                 frame_done;
  logic [STATE_W-1:0]   estado;
  logic [N_BUTTONS-1:0] b_event;
  logic                 pending;

  modport master (
    output b_in,
    output frame_done,
    input  estado,
    input  b_event,
    input  pending
  );

  modport slave (
    input  b_in,
    input  frame_done,
    output estado,
    output b_event,
    output pending
  );

endinterface

// File: rtl/seletor_estado_botoes_debouncer.sv
// ---------------------------------------------------------------------------
// debouncer_botao
// One button channel: 2-FF synchroniser, optional inversion, debouncer and
// press-edge detector producing a one-cycle event pulse.
//   clk     : system clock (rising edge)
//   rst     : synchronous active-high reset
//   b_raw   : raw asynchronous button input
//   b_event : one-cycle pulse after each accepted press
// With SELETOR_AUTO_REPEAT_EN defined and REPEAT_EN set, a held button also
// emits repeat pulses (timing from pkg_tamagotchi).
// ---------------------------------------------------------------------------
module debouncer_botao
  import pkg_tamagotchi::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
`ifdef SELETOR_AUTO_REPEAT_EN
  ,
  parameter bit REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic b_raw,
  output logic b_event
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Synchroniser reset value is the idle level of the raw pin.
  localparam logic RAW_IDLE = BTN_ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             event_q, event_d;
  logic             level;
  logic             press_edge;

`ifdef SELETOR_AUTO_REPEAT_EN
  logic [31:0] hold_q, hold_d;
  logic        repeating_q, repeating_d;
  logic [31:0] hold_limit;
`endif

  // The counter only runs while the synced level disagrees with the stable
  // level; any agreement (a bounce back) clears it, so only an unbroken run
  // of DEBOUNCE_CYCLES differing samples flips the stable level.
  always_comb begin
    sync1_d    = b_raw;
    sync2_d    = sync1_q;
    level      = sync2_q ^ BTN_ACTIVE_LOW;
    stable_d   = stable_q;
    cnt_d      = '0;
    if (level != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_edge = stable_d & ~stable_q;
    event_d    = press_edge;
`ifdef SELETOR_AUTO_REPEAT_EN
    hold_d      = '0;
    repeating_d = 1'b0;
    hold_limit  = repeating_q ? 32'(AUTO_REPEAT_PERIOD - 1)
                              : 32'(AUTO_REPEAT_DELAY - 1);
    // First repeat waits the long delay, later ones the short period.
    if (REPEAT_EN && stable_q && stable_d) begin
      repeating_d = repeating_q;
      if (hold_q == hold_limit) begin
        event_d     = 1'b1;
        hold_d      = '0;
        repeating_d = 1'b1;
      end else begin
        hold_d = hold_q + 32'd1;
      end
    end
`endif
  end

  // State registers; reset returns everything to the released condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= RAW_IDLE;
      sync2_q  <= RAW_IDLE;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      event_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
    end
  end

`ifdef SELETOR_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      repeating_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      repeating_q <= repeating_d;
    end
  end
`endif

  assign b_event = event_q;

endmodule

// File: rtl/seletor_estado_botoes.sv
// ---------------------------------------------------------------------------
// seletor_estado_botoes
// Button-driven image selector. Debounced next/prev/home presses compute a
// target image index; the target is committed to estado only when the
// display controller signals frame_done, so an image is never switched
// mid-transfer.
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset, overrides all inputs
//   bus : seletor_estado_botoes_if.slave (b_in, frame_done -> estado,
//         b_event, pending)
// Optional feature macro: SELETOR_AUTO_REPEAT_EN (auto-repeat on next/prev).
// ---------------------------------------------------------------------------
module seletor_estado_botoes
  import pkg_tamagotchi::*;
#(
  parameter int N_BUTTONS       = 3,
  parameter int NUM_STATES      = 4,
  parameter int STATE_W         = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  seletor_estado_botoes_if.slave  bus
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

  logic [N_BUTTONS-1:0] ev;
  sel_state_e           state_q, state_d;
  logic [STATE_W-1:0]   target_q, target_d;
  logic [STATE_W-1:0]   estado_q, estado_d;
  logic                 any_ev;

  // One synchroniser/debouncer/edge detector per button channel.
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    debouncer_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
`ifdef SELETOR_AUTO_REPEAT_EN
      ,
      .REPEAT_EN       ((i == BTN_NEXT) || (i == BTN_PREV))
`endif
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .b_raw   (bus.b_in[i]),
      .b_event (ev[i])
    );
  end

  // Next target from a base index; home beats prev beats next when several
  // presses land in the same cycle. Indices always stay below NUM_STATES.
  function automatic logic [STATE_W-1:0] calc_target(
    input logic [STATE_W-1:0] base,
    input logic               go_next,
    input logic               go_prev,
    input logic               go_home
  );
    logic [STATE_W-1:0] res;
    res = base;
    if (go_home) begin
      res = '0;
    end else if (go_prev) begin
      if (base == '0) res = LAST_STATE;
      else            res = base - STATE_W'(1);
    end else if (go_next) begin
      if (base >= LAST_STATE) res = '0;
      else                    res = base + STATE_W'(1);
    end
    return res;
  endfunction

  assign any_ev = ev[BTN_NEXT] | ev[BTN_PREV] | ev[BTN_HOME];

  // Next-state logic. In PENDING the accumulated target is the base for new
  // presses; when frame_done coincides with a press the committed value
  // equals that same target, so one expression serves both cases.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    estado_d = estado_q;
    case (state_q)
      IDLE: begin
        if (any_ev) begin
          target_d = calc_target(estado_q, ev[BTN_NEXT], ev[BTN_PREV], ev[BTN_HOME]);
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (any_ev) begin
          target_d = calc_target(target_q, ev[BTN_NEXT], ev[BTN_PREV], ev[BTN_HOME]);
        end
        if (bus.frame_done) begin
          estado_d = target_q;
          if (!any_ev) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      estado_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      estado_q <= estado_d;
    end
  end

  assign bus.estado  = estado_q;
  assign bus.b_event = ev;
  assign bus.pending = (state_q == PENDING);

endmodule
